// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the UART frame parser.
//   state_e        - parser FSM state encoding
//   ERR_*          - err_code values reported with frame_err
//   HDR*_DEFAULT   - default frame header bytes
`timescale 1ns/1ps
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_SEND    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload storage, DEPTH x 8 bits.
//   clk_i    - system clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
// The array has no reset; contents are only read after being written.
`timescale 1ns/1ps
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses HDR0 HDR1 LEN payload CSUM frames from a byte
// stream and replays a checked payload on a valid/ready output.
//   clk, rst_n          - clock, asynchronous active-low reset
//   data_in, data_vld   - incoming byte and its one-cycle strobe
//   m_data, m_valid,
//   m_ready, m_last     - payload output handshake
//   frame_ok            - pulse: frame passed its checksum
//   frame_err, err_code - pulse + reason: 1 length, 2 checksum, 3 timeout
//   drop                - pulse: byte discarded while sending
`timescale 1ns/1ps
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 209220,
    parameter logic [7:0] HDR0    = HDR0_DEFAULT,
    parameter logic [7:0] HDR1    = HDR1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_vld,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       drop
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic [AW-1:0] len_m1_q;   // LEN-1, so indices compare directly against it
    logic [7:0]    sum_q;
    logic [AW-1:0] wr_idx_q;
    logic [AW-1:0] rd_idx_q;   // index of the byte currently on m_data
    logic [7:0]    m_data_q;
    logic          m_valid_q;
    logic          m_last_q;
    logic          frame_ok_q;
    logic          frame_err_q;
    logic [1:0]    err_code_q;
    logic          drop_q;

    logic          buf_we_d;
    logic [AW-1:0] rd_nxt_d;
    logic [AW-1:0] rd_addr_d;
    logic [7:0]    rd_data;

    assign buf_we_d  = (state_q == ST_PAYLOAD) && data_vld;
    assign rd_nxt_d  = rd_idx_q + AW'(1);
    // Before the first beat is loaded, fetch byte 0; afterwards prefetch the next one.
    assign rd_addr_d = m_valid_q ? rd_nxt_d : '0;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we_d),
        .waddr_i (wr_idx_q),
        .wdata_i (data_in),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            len_m1_q    <= '0;
            sum_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_q      <= 1'b0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            drop_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (data_vld && data_in == HDR0) state_q <= ST_HDR;
                end
                ST_HDR: begin
                    if (data_vld) begin
                        if (data_in == HDR1)      state_q <= ST_LEN;
                        else if (data_in != HDR0) state_q <= ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (data_vld) begin
                        if (data_in == 8'd0 || data_in > MAX_LEN_B) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= ST_IDLE;
                        end else begin
                            len_m1_q <= AW'(data_in - 8'd1);
                            sum_q    <= data_in;
                            wr_idx_q <= '0;
                            state_q  <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (data_vld) begin
                        sum_q    <= sum_q + data_in;
                        wr_idx_q <= wr_idx_q + AW'(1);
                        if (wr_idx_q == len_m1_q) state_q <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (data_vld) begin
                        if (data_in == sum_q) begin
                            frame_ok_q <= 1'b1;
                            rd_idx_q   <= '0;
                            state_q    <= ST_SEND;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_SEND: begin
                    // The parser is busy replaying; incoming bytes are lost.
                    if (data_vld) drop_q <= 1'b1;
                    if (!m_valid_q) begin
                        // First SEND cycle coincides with frame_ok; present byte 0 next.
                        m_valid_q <= 1'b1;
                        m_data_q  <= rd_data;
                        m_last_q  <= (len_m1_q == '0);
                    end else if (m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            state_q   <= ST_IDLE;
                        end else begin
                            rd_idx_q <= rd_nxt_d;
                            m_data_q <= rd_data;
                            m_last_q <= (rd_nxt_d == len_m1_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Inter-byte timeout; an accepted byte in the same cycle takes priority.
            if ((state_q inside {ST_HDR, ST_LEN, ST_PAYLOAD, ST_CSUM}) && !data_vld) begin
                if (tmo_q == TMO_LAST) begin
                    tmo_q       <= '0;
                    frame_err_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                    state_q     <= ST_IDLE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
`timescale 1ns/1ps
module tb_uart_frame_parser;

    localparam int MAXL = 16;
    localparam int TMO  = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_vld;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       drop;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN (MAXL),
        .TIMEOUT (TMO),
        .HDR0    (8'h55),
        .HDR1    (8'hAA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_vld  (data_vld),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .drop      (drop)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected and observed event records for the current segment.
    int         exp_ok = 0, exp_drop = 0;
    int         exp_err_q[$];
    logic [8:0] exp_beat_q[$];   // {last, data}
    int         obs_ok = 0, obs_drop = 0;
    int         obs_err_q[$];
    logic [8:0] obs_beat_q[$];

    // m_ready policy: 0 always ready, 1 toggle, 2 random, 3 never ready
    int rdy_mode = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ~m_ready;
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    logic       stall_prev = 1'b0;
    logic       ok_prev    = 1'b0;
    logic [7:0] data_prev;
    logic       last_prev;
    always @(negedge clk) begin
        if (frame_ok) obs_ok++;
        if (frame_err) obs_err_q.push_back(int'(err_code));
        if (drop) obs_drop++;
        if (m_valid && m_ready) obs_beat_q.push_back({m_last, m_data});
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_data", m_data, data_prev);
                chk("stall_last", m_last, last_prev);
            end
            if (ok_prev) chk("valid_after_ok", m_valid, 1);
            stall_prev = m_valid && !m_ready;
            ok_prev    = frame_ok;
            data_prev  = m_data;
            last_prev  = m_last;
        end else begin
            stall_prev = 1'b0;
            ok_prev    = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        data_in  = b;
        data_vld = 1'b1;
        @(posedge clk);
        #1;
        data_vld = 1'b0;
    endtask

    task automatic expect_payload(input logic [7:0] pl[$]);
        for (int i = 0; i < pl.size(); i++)
            exp_beat_q.push_back({(i == pl.size() - 1), pl[i]});
    endtask

    task automatic compare_seg(input string tag);
        chk({tag, "_ok"}, obs_ok, exp_ok);
        chk({tag, "_drop"}, obs_drop, exp_drop);
        chk({tag, "_nerr"}, obs_err_q.size(), exp_err_q.size());
        for (int i = 0; i < exp_err_q.size() && i < obs_err_q.size(); i++)
            chk({tag, "_errcode"}, obs_err_q[i], exp_err_q[i]);
        chk({tag, "_nbeats"}, obs_beat_q.size(), exp_beat_q.size());
        for (int i = 0; i < exp_beat_q.size() && i < obs_beat_q.size(); i++)
            chk({tag, "_beat"}, int'(obs_beat_q[i]), int'(exp_beat_q[i]));
        exp_ok = 0; exp_drop = 0; obs_ok = 0; obs_drop = 0;
        exp_err_q.delete(); obs_err_q.delete();
        exp_beat_q.delete(); obs_beat_q.delete();
    endtask

    // Directed vectors: byte stream and the outcome the frame rules imply.
    typedef struct {
        int           n;
        logic [159:0] bytes;   // byte 0 at the most significant used position
        int           exp_ok;
        int           exp_err;
        int           exp_nb;
        logic [127:0] exp_d;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vector(input int idx);
        vec_t v;
        v = vecs[idx];
        rdy_mode = 0;
        exp_ok = v.exp_ok;
        if (v.exp_err != 0) exp_err_q.push_back(v.exp_err);
        for (int i = 0; i < v.exp_nb; i++)
            exp_beat_q.push_back({(i == v.exp_nb - 1), v.exp_d[8*(v.exp_nb-1-i) +: 8]});
        for (int i = 0; i < v.n; i++)
            send_byte(v.bytes[8*(v.n-1-i) +: 8]);
        idle(40);
        compare_seg($sformatf("vec%0d", idx));
    endtask

    // Random segment generator with expectations from the frame rules.
    task automatic rand_segment(input int s);
        int         kind, len, total, k, p;
        logic [7:0] pl[$];
        logic [7:0] csum, b;
        kind     = $urandom_range(0, 4);
        rdy_mode = $urandom_range(0, 2);
        case (kind)
            0, 1: begin
                len   = $urandom_range(1, MAXL);
                total = len;
                for (int i = 0; i < len; i++) begin
                    pl.push_back(8'($urandom_range(0, 255)));
                    total += pl[i];
                end
                csum = 8'(total % 256);
                send_byte(8'h55); send_byte(8'hAA); send_byte(8'(len));
                foreach (pl[i]) begin
                    idle($urandom_range(0, 4));
                    send_byte(pl[i]);
                end
                if (kind == 0) begin
                    exp_ok = 1;
                    expect_payload(pl);
                    send_byte(csum);
                end else begin
                    exp_err_q.push_back(2);
                    send_byte(csum ^ 8'($urandom_range(1, 255)));
                end
                idle(150);
            end
            2: begin
                len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXL + 1, 255);
                exp_err_q.push_back(1);
                send_byte(8'h55); send_byte(8'hAA); send_byte(8'(len));
                idle(10);
            end
            3: begin
                k = $urandom_range(1, 4);
                for (int i = 0; i < k; i++) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h55) b = 8'h56;
                    send_byte(b);
                end
                idle(10);
            end
            default: begin
                p = $urandom_range(0, 2);
                send_byte(8'h55);
                if (p >= 1) send_byte(8'hAA);
                if (p == 2) begin
                    len = $urandom_range(1, MAXL);
                    send_byte(8'(len));
                    k = $urandom_range(0, len);
                    for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)));
                end
                exp_err_q.push_back(3);
                idle(TMO + 20);
            end
        endcase
        compare_seg($sformatf("rand%0d_k%0d", s, kind));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic found;

        vecs[0] = '{n:7,  bytes:160'({8'h55,8'hAA,8'h03,8'h01,8'h02,8'h03,8'h09}),
                    exp_ok:1, exp_err:0, exp_nb:3, exp_d:128'({8'h01,8'h02,8'h03})};
        vecs[1] = '{n:6,  bytes:160'({8'h55,8'hAA,8'h02,8'h10,8'h20,8'h00}),
                    exp_ok:0, exp_err:2, exp_nb:0, exp_d:128'h0};
        vecs[2] = '{n:3,  bytes:160'({8'h55,8'hAA,8'h00}),
                    exp_ok:0, exp_err:1, exp_nb:0, exp_d:128'h0};
        vecs[3] = '{n:3,  bytes:160'({8'h55,8'hAA,8'h11}),
                    exp_ok:0, exp_err:1, exp_nb:0, exp_d:128'h0};
        vecs[4] = '{n:7,  bytes:160'({8'h12,8'h55,8'h55,8'hAA,8'h01,8'h05,8'h06}),
                    exp_ok:1, exp_err:0, exp_nb:1, exp_d:128'(8'h05)};
        vecs[5] = '{n:20, bytes:{8'h55,8'hAA,8'h10,128'h000102030405060708090A0B0C0D0E0F,8'h88},
                    exp_ok:1, exp_err:0, exp_nb:16, exp_d:128'h000102030405060708090A0B0C0D0E0F};
        vecs[6] = '{n:5,  bytes:160'({8'h55,8'hAA,8'h01,8'hFF,8'h00}),
                    exp_ok:1, exp_err:0, exp_nb:1, exp_d:128'(8'hFF)};
        vecs[7] = '{n:7,  bytes:160'({8'h55,8'h13,8'h55,8'hAA,8'h01,8'h7F,8'h80}),
                    exp_ok:1, exp_err:0, exp_nb:1, exp_d:128'(8'h7F)};

        rst_n    = 1'b0;
        data_vld = 1'b0;
        data_in  = 8'h00;
        idle(3);
        @(negedge clk);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1'b1;
        idle(2);
        obs_ok = 0; obs_drop = 0; obs_err_q.delete(); obs_beat_q.delete();

        for (int i = 0; i < 8; i++) run_vector(i);

        // Timeout after a partial frame, exactly TIMEOUT idle clocks.
        rdy_mode = 0;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
        k = 0; found = 1'b0;
        while (!found && k < 2 * TMO) begin
            @(posedge clk); @(negedge clk);
            k++;
            if (frame_err) found = 1'b1;
        end
        chk("tmo_latency", k, TMO);
        exp_err_q.push_back(3);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        exp_ok = 1;
        exp_beat_q.push_back({1'b1, 8'h7F});
        idle(20);
        compare_seg("timeout");

        // Byte arriving on the very clock the timeout would fire wins.
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
        idle(TMO - 2);
        send_byte(8'h20);
        send_byte(8'h32);
        exp_ok = 1;
        exp_beat_q.push_back({1'b0, 8'h10});
        exp_beat_q.push_back({1'b1, 8'h20});
        idle(20);
        compare_seg("tmo_race");

        // Toggling ready with a header byte injected during SEND.
        rdy_mode = 1;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAE);
        idle(2);
        send_byte(8'h55);
        exp_ok = 1;
        exp_drop = 1;
        exp_beat_q.push_back({1'b0, 8'h11});
        exp_beat_q.push_back({1'b0, 8'h22});
        exp_beat_q.push_back({1'b0, 8'h33});
        exp_beat_q.push_back({1'b1, 8'h44});
        idle(30);
        compare_seg("stall_drop");

        // Reset during PAYLOAD, then a clean frame.
        rdy_mode = 0;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk); #2;
        rst_n = 1'b0;
        idle(2);
        @(negedge clk); #2;
        rst_n = 1'b1;
        send_byte(8'h03); send_byte(8'h04);
        idle(TMO + 10);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h0D);
        exp_ok = 1;
        exp_beat_q.push_back({1'b0, 8'h05});
        exp_beat_q.push_back({1'b1, 8'h06});
        idle(20);
        compare_seg("rst_payload");

        // Reset while a beat is stalled in SEND drops it immediately.
        rdy_mode = 3;
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h7A);
        idle(3);
        @(negedge clk);
        chk("send_valid_before_rst", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_valid, 0);
        chk("rst_async_data", m_data, 0);
        rdy_mode = 0;
        idle(2);
        @(negedge clk); #2;
        rst_n = 1'b1;
        exp_ok = 1;
        idle(20);
        compare_seg("rst_send");

        for (int s = 0; s < 40; s++) rand_segment(s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
